hack_data_memory: RTL and testbench

Data-memory responder for the Hack CPU's M-port, completing the other side of `addressM`/`outM`/`loadM`/`inM`. It decodes the 16-bit address into three regions:
- 16K-word RAM.
- 8K-word screen buffer, with a second read port for the display controller.
- Memory-mapped keyboard register, backed by a small FIFO fed through a valid/ready handshake.

It sits between the CPU and the top-level I/O.

---
 rtl/hack_mem_pkg.sv | 32 +++
 rtl/kbd_fifo.sv | 63 ++++++
 rtl/hack_data_memory.sv | 75 +++++++
 tb/tb_hack_data_memory.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared address map and region decode for the Hack data-memory responder.
package hack_mem_pkg;

    localparam logic [15:0] RAM_BASE  = 16'h0000;
    localparam int          RAM_WORDS = 16384;
    localparam logic [15:0] SCR_BASE  = 16'h4000;
    localparam int          SCR_WORDS = 8192;
    localparam logic [15:0] KBD_ADDR  = 16'h6000;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_SCR  = 2'd1,
        REG_KBD  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // Only the single word at KBD_ADDR is mapped above the screen.
    function automatic region_e decode_region(input logic [15:0] addr);
        region_e r;
        if (addr[15:14] == RAM_BASE[15:14]) begin
            r = REG_RAM;
        end else if (addr[15:13] == SCR_BASE[15:13]) begin
            r = REG_SCR;
        end else if (addr == KBD_ADDR) begin
            r = REG_KBD;
        end else begin
            r = REG_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Keyboard key-code FIFO: drops zero codes, ignores pops when empty.
module kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [15:0]                push_data,
    output logic                       push_ready,
    input  logic                       pop,
    output logic [15:0]                head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [15:0]   mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Ready reflects occupancy only, so a same-cycle pop never opens the door.
    assign push_ready = (count_r != CW'(DEPTH));
    assign do_push_s  = push_valid && push_ready && (push_data != 16'h0000);
    assign do_pop_s   = pop && (count_r != CW'(0));
    assign count      = count_r;

    // Head of queue, or zero meaning "no key" when empty.
    always_comb begin
        head = 16'h0000;
        if (count_r != CW'(0)) begin
            head = mem_r[rd_ptr_r];
        end else begin
            head = 16'h0000;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data memory: RAM, screen buffer with display read port, keyboard FIFO.
module hack_data_memory
    import hack_mem_pkg::*;
#(
    parameter int KBD_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [15:0]                    addressM,
    input  logic [15:0]                    outM,
    input  logic                           loadM,
    output logic [15:0]                    inM,
    input  logic [12:0]                    scr_addr,
    output logic [15:0]                    scr_data,
    input  logic [15:0]                    kbd_data,
    input  logic                           kbd_valid,
    output logic                           kbd_ready,
    output logic [$clog2(KBD_DEPTH+1)-1:0] kbd_count
);

    logic [15:0] ram_r [RAM_WORDS];
    logic [15:0] scr_r [SCR_WORDS];
    logic [15:0] scr_data_r;
    logic [15:0] kbd_head_s;
    logic        kbd_pop_s;
    region_e     region_s;

    assign region_s  = decode_region(addressM);
    assign kbd_pop_s = loadM && (region_s == REG_KBD);
    assign scr_data  = scr_data_r;

    kbd_fifo #(
        .DEPTH(KBD_DEPTH)
    ) u_kbd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_valid(kbd_valid),
        .push_data (kbd_data),
        .push_ready(kbd_ready),
        .pop       (kbd_pop_s),
        .head      (kbd_head_s),
        .count     (kbd_count)
    );

    // CPU read mux: combinational so the CPU sees data in the same cycle.
    always_comb begin
        inM = 16'h0000;
        case (region_s)
            REG_RAM:  inM = ram_r[addressM[13:0]];
            REG_SCR:  inM = scr_r[addressM[12:0]];
            REG_KBD:  inM = kbd_head_s;
            default:  inM = 16'h0000;
        endcase
    end

    // CPU writes; array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && loadM && (region_s == REG_RAM)) begin
            ram_r[addressM[13:0]] <= outM;
        end
        if (!reset && loadM && (region_s == REG_SCR)) begin
            scr_r[addressM[12:0]] <= outM;
        end
    end

    // Display port: read-before-write against a same-cycle CPU write.
    always_ff @(posedge clk) begin
        if (reset) begin
            scr_data_r <= 16'h0000;
        end else begin
            scr_data_r <= scr_r[scr_addr];
        end
    end

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed self-checking bench for hack_data_memory.
module tb_hack_data_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addressM;
    logic [15:0] outM;
    logic        loadM;
    logic [15:0] inM;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic [15:0] kbd_data;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [2:0]  kbd_count;

    int n_checks = 0;
    int n_fails  = 0;

    hack_data_memory #(.KBD_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .addressM (addressM),
        .outM     (outM),
        .loadM    (loadM),
        .inM      (inM),
        .scr_addr (scr_addr),
        .scr_data (scr_data),
        .kbd_data (kbd_data),
        .kbd_valid(kbd_valid),
        .kbd_ready(kbd_ready),
        .kbd_count(kbd_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        addressM = a; outM = d; loadM = 1'b1;
        tick();
        loadM = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addressM = a;
        #1;
        check_eq(tag, inM, exp);
    endtask

    task automatic push(input logic [15:0] d);
        kbd_valid = 1'b1; kbd_data = d;
        tick();
        kbd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; addressM = 16'h0000; outM = 16'h0000; loadM = 1'b0;
        scr_addr = 13'h0000; kbd_data = 16'h0000; kbd_valid = 1'b0;
        tick();
        tick();
        check_eq("rst_scr_data", scr_data, 16'h0000);
        check_eq("rst_count", 16'(kbd_count), 16'h0000);
        check_eq("rst_ready", 16'(kbd_ready), 16'h0001);
        cpu_read("rst_kbd", 16'h6000, 16'h0000);
        cpu_read("rst_unmapped", 16'h7000, 16'h0000);
        reset = 1'b0;

        // RAM write/read and unmapped write
        cpu_write(16'h0005, 16'h1234);
        cpu_read("ram_rd_0005", 16'h0005, 16'h1234);
        cpu_write(16'h0000, 16'h1111);
        cpu_write(16'h4000, 16'h2222);
        cpu_write(16'h8000, 16'hBEEF);
        cpu_read("unmapped_8000", 16'h8000, 16'h0000);
        cpu_read("ram_0000_intact", 16'h0000, 16'h1111);
        cpu_read("scr_4000_intact", 16'h4000, 16'h2222);
        cpu_read("kbd_after_8000", 16'h6000, 16'h0000);

        // Screen read-before-write on the display port
        cpu_write(16'h4010, 16'h5A5A);
        scr_addr = 13'h010;
        cpu_write(16'h4010, 16'hFFFF);
        check_eq("scr_old_value", scr_data, 16'h5A5A);
        tick();
        check_eq("scr_new_value", scr_data, 16'hFFFF);
        cpu_read("cpu_rd_4010", 16'h4010, 16'hFFFF);

        // RAM word that must survive the later reset
        cpu_write(16'h0100, 16'hCAFE);

        // Keyboard pushes with a zero code in the middle
        push(16'h0041); push(16'h0042); push(16'h0000); push(16'h0043); push(16'h0044);
        check_eq("full_count", 16'(kbd_count), 16'h0004);
        check_eq("full_ready", 16'(kbd_ready), 16'h0000);
        kbd_valid = 1'b1; kbd_data = 16'h0045;
        tick();
        check_eq("held_off_count", 16'(kbd_count), 16'h0004);
        cpu_read("kbd_head_41", 16'h6000, 16'h0041);
        cpu_read("unmapped_6001", 16'h6001, 16'h0000);

        // Pops: the first one coincides with the held-off offer, which must not enter
        addressM = 16'h6000; loadM = 1'b1;
        tick();
        kbd_valid = 1'b0;
        check_eq("pop1_count", 16'(kbd_count), 16'h0003);
        check_eq("pop1_ready", 16'(kbd_ready), 16'h0001);
        check_eq("pop1_head", inM, 16'h0042);
        tick();
        check_eq("pop2_head", inM, 16'h0043);
        tick();
        check_eq("pop3_head", inM, 16'h0044);
        tick();
        check_eq("pop4_head", inM, 16'h0000);
        check_eq("pop4_count", 16'(kbd_count), 16'h0000);
        tick();
        loadM = 1'b0;
        check_eq("pop_empty_count", 16'(kbd_count), 16'h0000);

        // Simultaneous push and pop at two entries
        push(16'h0061); push(16'h0062);
        check_eq("two_count", 16'(kbd_count), 16'h0002);
        kbd_valid = 1'b1; kbd_data = 16'h0063; addressM = 16'h6000; loadM = 1'b1;
        tick();
        kbd_valid = 1'b0; loadM = 1'b0;
        check_eq("pushpop_count", 16'(kbd_count), 16'h0002);
        cpu_read("pushpop_head", 16'h6000, 16'h0062);

        // Fill, then reset with a discarded write and push in the reset cycle
        push(16'h0064); push(16'h0065);
        check_eq("refill_count", 16'(kbd_count), 16'h0004);
        reset = 1'b1; addressM = 16'h0100; outM = 16'hDEAD; loadM = 1'b1;
        kbd_valid = 1'b1; kbd_data = 16'h0066;
        tick();
        reset = 1'b0; loadM = 1'b0; kbd_valid = 1'b0;
        check_eq("post_rst_count", 16'(kbd_count), 16'h0000);
        check_eq("post_rst_ready", 16'(kbd_ready), 16'h0001);
        cpu_read("post_rst_ram", 16'h0100, 16'hCAFE);
        cpu_read("post_rst_kbd", 16'h6000, 16'h0000);

        // Push and pop together on an empty FIFO: pop ignored
        kbd_valid = 1'b1; kbd_data = 16'h0077; addressM = 16'h6000; loadM = 1'b1;
        tick();
        kbd_valid = 1'b0; loadM = 1'b0;
        check_eq("empty_pushpop_count", 16'(kbd_count), 16'h0001);
        cpu_read("empty_pushpop_head", 16'h6000, 16'h0077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
